mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter sharing the single-ported unified MEMORY between three requesters: CPU data port (loads/stores), CPU instruction fetch, and the SPI DMA engine. Sits between those requesters and the memory array. It owns request/grant handshakes, issue ordering, read-data return and the CPU stall signal. Fixed priority is backed by an aging counter so SPI traffic cannot be starved by a busy CPU.

## Interface
Parameters:
- `W_CPU`, 32, address and data width
- `SPI_MAX_WAIT`, 4, number of consecutive denied cycles after which a pending SPI request is promoted to top priority (1..15)

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `d_req`, `i_req`, `s_req`  in  1 each  access request: data / ifetch / SPI
- `d_we`, `s_we`  in  1 each  write enable (ifetch is read-only)
- `d_addr`, `i_addr`, `s_addr`  in  W_CPU each  byte address
- `d_wdata`, `s_wdata`  in  W_CPU each  write data
- `d_gnt`, `i_gnt`, `s_gnt`  out  1 each  request accepted and issued this cycle
- `d_rvalid`, `i_rvalid`, `s_rvalid`  out  1 each  read data valid on `rdata`
- `rdata`  out  W_CPU  read data, shared by all requesters; qualified by the per-requester rvalid
- `cpu_stall`  out  1  `(d_req & ~d_gnt) | (i_req & ~i_gnt)`
- `mem_en`, `mem_we`  out  1 each  memory command
- `mem_addr`, `mem_wdata`  out  W_CPU each  memory command payload
- `mem_rdata`  in  W_CPU  memory read data, valid one cycle after `mem_en & ~mem_we`

## Operation
- Handshake: a requester raises req with addr/we/wdata stable and holds them unchanged until it sees gnt high at a rising edge. Dropping req before gnt is legal; the request is then abandoned.
- Exactly one grant per cycle, at most. gnt is combinational from the current reqs and the aging state. In the grant cycle the arbiter drives `mem_en=1` and copies that requester's addr/we/wdata onto `mem_*`. If no request is pending: `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
- Priority order: data > ifetch > SPI.
  - Exception: when `spi_age == SPI_MAX_WAIT` and `s_req=1`, SPI wins over both CPU requesters.
- `spi_age` is a 4-bit counter:
  - cleared on reset, on `s_gnt`, and whenever `s_req=0`;
  - incremented on each cycle with `s_req & ~s_gnt`;
  - saturates at SPI_MAX_WAIT.
- Read return: a registered `rsel` (2 bits: none/D/I/S) records the owner of a read issued this cycle. Next cycle, the matching rvalid is 1 and `rdata = mem_rdata`. With `rsel=none`, `rdata=0`.
- Writes complete at grant; no rvalid is raised for a write.
- Back-to-back issue is allowed: a new grant may occur in the same cycle as the previous read's rvalid.
- `cpu_stall` is high whenever a CPU request is pending but not granted. The CPU holds its PC and state while stalled.

## Timing
- Reset values:
  - all gnt, rvalid and `mem_en`/`mem_we` are 0;
  - `rdata`, `mem_addr` and `mem_wdata` are 0;
  - `rsel=none`, `spi_age=0`, `cpu_stall=0`.
- Gnt and `cpu_stall` are forced to 0 while `rst=1`.
- Read latency: grant at cycle N, rvalid and rdata at cycle N+1. Sustained throughput is 1 access per cycle.
- Reset mid-operation: a read granted in the cycle before reset is asserted produces no rvalid. `rsel` is cleared by the reset edge.
- Simultaneous requests from all three with `spi_age<SPI_MAX_WAIT`: d granted. i and s wait, and `spi_age` increments.
- Promotion edge: SPI is granted on the cycle its age reaches SPI_MAX_WAIT, even if d and i are pending. `spi_age` returns to 0 on the next edge.
- A requester that is granted and immediately re-requests competes normally on the next cycle. There is no lock or burst hold.

## Structure
- Shared package/header holds:
  - `ARB_NONE`=2'd0, `ARB_D`=2'd1, `ARB_I`=2'd2, `ARB_S`=2'd3;
  - `W_ARB_SEL`=2;
  - `W_SPI_AGE`=4.
- `W_CPU` reuses the existing project define.
- One sub-module: `arb_priority`. It is combinational and takes the three reqs plus a promote flag, and returns a one-hot grant and the encoded select.
- `mem_arbiter` holds `spi_age`, `rsel`, the command mux and the rdata routing.

## Test plan
- Single data read: `d_req=1`, `d_addr=0x40`, memory holds 0xDEADBEEF at 0x40.
  - `d_gnt` and `mem_en` in cycle N with `mem_addr=0x40`.
  - Cycle N+1: `d_rvalid=1`, `rdata=0xDEADBEEF`, `cpu_stall=0` throughout.
- Contention: d, i and s requests all held continuously, `SPI_MAX_WAIT=4`.
  - Grants in cycles 0..3 go to d.
  - Cycle 4 goes to s (age=4).
  - After that, d wins again while it keeps requesting. `cpu_stall=1` in cycle 4.
- Write then read: s writes 0x12345678 to 0x100 (no `s_rvalid`). Next cycle, i reads 0x100 → `i_rvalid=1`, `rdata=0x12345678` one cycle after `i_gnt`.
- Back-to-back reads: i reads at 0x0, 0x4 and 0x8 on consecutive cycles. Three consecutive `i_rvalid` pulses arrive with the correct data and no bubble.
- Reset mid-read: `i_gnt` at cycle N, `rst=1` at cycle N+1 → `i_rvalid=0` at N+1. All outputs are zero during reset, and `spi_age=0` after release.
- Abandon: `s_req` held 3 cycles behind d, then dropped → `spi_age` returns to 0 and no `s_gnt` is issued.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types and widths for the unified-memory arbiter.
//   arb_sel_t  : encoded owner of an access (none / data / ifetch / SPI)
//   W_ARB_SEL  : width of arb_sel_t
//   W_SPI_AGE  : width of the SPI aging counter
//   W_CPU_DEFAULT : project-wide CPU address/data width
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int W_CPU_DEFAULT = 32;
    localparam int W_ARB_SEL     = 2;
    localparam int W_SPI_AGE     = 4;

    typedef enum logic [W_ARB_SEL-1:0] {
        ARB_NONE = 2'd0,
        ARB_D    = 2'd1,
        ARB_I    = 2'd2,
        ARB_S    = 2'd3
    } arb_sel_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the three requester handshakes, the read-return path, the CPU stall
// and the memory command bus.
//   slave  : the arbiter's view (requests and mem_rdata in; grants, rvalids,
//            rdata, cpu_stall and memory command out)
//   master : the environment's view (requesters plus memory array)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int W_CPU = 32
);
    // Requesters
    logic             d_req, i_req, s_req;
    logic             d_we, s_we;
    logic [W_CPU-1:0] d_addr, i_addr, s_addr;
    logic [W_CPU-1:0] d_wdata, s_wdata;
    logic             d_gnt, i_gnt, s_gnt;
    logic             d_rvalid, i_rvalid, s_rvalid;
    logic [W_CPU-1:0] rdata;
    logic             cpu_stall;
    // Memory command bus
    logic             mem_en, mem_we;
    logic [W_CPU-1:0] mem_addr, mem_wdata;
    logic [W_CPU-1:0] mem_rdata;

    modport slave (
        input  d_req, i_req, s_req, d_we, s_we,
        input  d_addr, i_addr, s_addr, d_wdata, s_wdata,
        input  mem_rdata,
        output d_gnt, i_gnt, s_gnt, d_rvalid, i_rvalid, s_rvalid,
        output rdata, cpu_stall,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output d_req, i_req, s_req, d_we, s_we,
        output d_addr, i_addr, s_addr, d_wdata, s_wdata,
        output mem_rdata,
        input  d_gnt, i_gnt, s_gnt, d_rvalid, i_rvalid, s_rvalid,
        input  rdata, cpu_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_arb_priority.sv
// -----------------------------------------------------------------------------
// arb_priority
// Combinational fixed-priority picker: data > ifetch > SPI, except that a
// promoted SPI request beats both CPU requesters.
//   i_d_req, i_i_req, i_s_req : pending requests
//   i_promote                 : SPI has waited long enough to jump the queue
//   o_gnt                     : one-hot grant, bit0 = data, bit1 = ifetch, bit2 = SPI
//   o_sel                     : encoded winner (ARB_NONE when idle)
// -----------------------------------------------------------------------------
module arb_priority
    import mem_arbiter_pkg::*;
(
    input  logic     i_d_req,
    input  logic     i_i_req,
    input  logic     i_s_req,
    input  logic     i_promote,
    output logic [2:0] o_gnt,
    output arb_sel_t o_sel
);

    always_comb begin
        // NOTE: every output gets a default before the if-chain, so no path
        // leaves it unassigned and no latch is inferred.
        o_gnt = 3'b000;
        o_sel = ARB_NONE;
        if (i_promote && i_s_req) begin
            o_gnt = 3'b100;
            o_sel = ARB_S;
        end else if (i_d_req) begin
            o_gnt = 3'b001;
            o_sel = ARB_D;
        end else if (i_i_req) begin
            o_gnt = 3'b010;
            o_sel = ARB_I;
        end else if (i_s_req) begin
            o_gnt = 3'b100;
            o_sel = ARB_S;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single-ported unified memory between CPU data, CPU ifetch and the
// SPI DMA engine. One access is issued per cycle; reads return one cycle later
// on the shared rdata bus, qualified by the owner's rvalid. An aging counter
// promotes SPI to top priority after SPI_MAX_WAIT consecutive denied cycles.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : mem_arbiter_if.slave (requests, grants, read return, stall, memory)
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int W_CPU        = W_CPU_DEFAULT,
    parameter int SPI_MAX_WAIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam logic [W_SPI_AGE-1:0] AGE_MAX = W_SPI_AGE'(SPI_MAX_WAIT);

    logic [W_SPI_AGE-1:0] r_spi_age;
    arb_sel_t             r_rsel;

    logic                 w_d_req, w_i_req, w_s_req;
    logic                 w_promote;
    logic [2:0]           w_gnt;
    arb_sel_t             w_sel;
    logic                 w_mem_we;
    logic [W_CPU-1:0]     w_mem_addr, w_mem_wdata;
    logic                 w_ret;

    // Requests are masked during reset so grants, stall and the command bus
    // all read zero without a separate clear path.
    assign w_d_req   = bus.d_req & ~rst;
    assign w_i_req   = bus.i_req & ~rst;
    assign w_s_req   = bus.s_req & ~rst;
    assign w_promote = (r_spi_age == AGE_MAX);

    arb_priority u_arb_priority (
        .i_d_req   (w_d_req),
        .i_i_req   (w_i_req),
        .i_s_req   (w_s_req),
        .i_promote (w_promote),
        .o_gnt     (w_gnt),
        .o_sel     (w_sel)
    );

    // Command mux: the winner's payload goes to memory; idle drives all zero.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        case (w_sel)
            ARB_D: begin
                w_mem_we    = bus.d_we;
                w_mem_addr  = bus.d_addr;
                w_mem_wdata = bus.d_wdata;
            end
            ARB_I: begin
                w_mem_addr  = bus.i_addr;
            end
            ARB_S: begin
                w_mem_we    = bus.s_we;
                w_mem_addr  = bus.s_addr;
                w_mem_wdata = bus.s_wdata;
            end
            default: ;
        endcase
    end

    assign bus.d_gnt     = w_gnt[0];
    assign bus.i_gnt     = w_gnt[1];
    assign bus.s_gnt     = w_gnt[2];
    assign bus.mem_en    = (w_sel != ARB_NONE);
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.cpu_stall = (w_d_req & ~w_gnt[0]) | (w_i_req & ~w_gnt[1]);

    // Read return is suppressed while reset is held, so a read issued just
    // before reset never surfaces even though rsel clears only on the edge.
    assign w_ret        = ~rst & (r_rsel != ARB_NONE);
    assign bus.d_rvalid = ~rst & (r_rsel == ARB_D);
    assign bus.i_rvalid = ~rst & (r_rsel == ARB_I);
    assign bus.s_rvalid = ~rst & (r_rsel == ARB_S);
    assign bus.rdata    = w_ret ? bus.mem_rdata : '0;

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values and ordering between always blocks cannot matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spi_age <= '0;
            r_rsel    <= ARB_NONE;
        end else begin
            // Age counts consecutive denied SPI cycles, saturating at the limit.
            if (!bus.s_req || w_gnt[2]) begin
                r_spi_age <= '0;
            end else if (r_spi_age != AGE_MAX) begin
                r_spi_age <= r_spi_age + W_SPI_AGE'(1);
            end
            // Remember who owns the read issued this cycle; writes return nothing.
            r_rsel <= ((w_sel != ARB_NONE) && !w_mem_we) ? w_sel : ARB_NONE;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A memory array model answers reads one
// cycle after issue. A reference model tracks SPI wait streak, pending read
// owner and memory contents from the arbitration rules and predicts every
// output each cycle; directed scenarios also check fixed expected values.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int W    = 32;
    localparam int MAXW = 4;
    localparam int VW   = 3 + 2 + W + W + 1 + 3 + W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.W_CPU(W)) bus ();

    mem_arbiter #(.W_CPU(W), .SPI_MAX_WAIT(MAXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [W-1:0] init_word(input int idx);
        if (idx == 16) return 32'hDEAD_BEEF;
        return (W'(idx) * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    // Memory array: reloaded during reset, read data registered.
    logic [W-1:0] mem [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
            bus.mem_rdata <= '0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           m_age;
    int           m_rsel;
    logic [W-1:0] m_rexp;
    logic [W-1:0] ref_mem [256];

    // Current stimulus
    bit           dr, ir, sr, dwe, swe;
    logic [W-1:0] da, ia, sa, dwd, swd;

    task automatic idle_inputs();
        dr = 0; ir = 0; sr = 0; dwe = 0; swe = 0;
        da = '0; ia = '0; sa = '0; dwd = '0; swd = '0;
    endtask

    task automatic apply(input bit r);
        @(negedge clk);
        rst = r;
        bus.d_req = dr;  bus.i_req = ir;  bus.s_req = sr;
        bus.d_we  = dwe; bus.s_we  = swe;
        bus.d_addr = da; bus.i_addr = ia; bus.s_addr = sa;
        bus.d_wdata = dwd; bus.s_wdata = swd;
        #3;
    endtask

    // 0 none, 1 data, 2 ifetch, 3 SPI
    function automatic int exp_winner();
        if (sr && m_age >= MAXW) return 3;
        if (dr) return 1;
        if (ir) return 2;
        if (sr) return 3;
        return 0;
    endfunction

    function automatic logic [VW-1:0] expect_vec();
        int           win;
        logic [2:0]   g;
        logic         en, we, st;
        logic [W-1:0] a, wd, rd;
        logic [2:0]   rv;
        win = exp_winner();
        g = 3'b000; en = 0; we = 0; a = '0; wd = '0;
        case (win)
            1: begin g = 3'b001; en = 1; we = dwe; a = da; wd = dwd; end
            2: begin g = 3'b010; en = 1; a = ia; end
            3: begin g = 3'b100; en = 1; we = swe; a = sa; wd = swd; end
            default: ;
        endcase
        st = (dr && win != 1) || (ir && win != 2);
        rv = 3'b000;
        if (m_rsel != 0) rv[m_rsel-1] = 1'b1;
        rd = (m_rsel != 0) ? m_rexp : '0;
        return {g, en, we, a, wd, st, rv, rd};
    endfunction

    function automatic logic [VW-1:0] observe_vec();
        return {bus.s_gnt, bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_we,
                bus.mem_addr, bus.mem_wdata, bus.cpu_stall,
                bus.s_rvalid, bus.i_rvalid, bus.d_rvalid, bus.rdata};
    endfunction

    // Advance the model across the coming rising edge, then wait for it.
    task automatic commit(input bit r, output int won);
        logic [W-1:0] a;
        bit           we;
        won = r ? 0 : exp_winner();
        if (r) begin
            m_age = 0;
            m_rsel = 0;
            for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
        end else begin
            if (!sr || won == 3) m_age = 0;
            else if (m_age < MAXW) m_age++;
            m_rsel = 0;
            if (won != 0) begin
                a  = (won == 1) ? da : (won == 2) ? ia : sa;
                we = (won == 1) ? dwe : (won == 3) ? swe : 1'b0;
                if (we) ref_mem[a[9:2]] = (won == 1) ? dwd : swd;
                else begin
                    m_rsel = won;
                    m_rexp = ref_mem[a[9:2]];
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        logic [VW-1:0] obs;
        int won;
        dr = 1; ir = 1; sr = 1; dwe = 0; swe = 1;
        da = 32'h40; ia = 32'h44; sa = 32'h80; dwd = 32'h1; swd = 32'h2;
        for (int i = 0; i < 3; i++) begin
            apply(1);
            obs = observe_vec();
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset cyc %0d got %h want 0", i, obs);
            end
            commit(1, won);
        end
        idle_inputs();
    endtask

    task automatic test_single_read();
        logic [VW-1:0] obs, expv;
        int won;
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            if (i == 0) begin dr = 1; da = 32'h40; dwd = 32'h0BAD; end
            apply(0);
            obs = observe_vec(); expv = expect_vec();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL single_read cyc %0d got %h want %h", i, obs, expv);
            end
            checks++;
            if (i == 1 && (bus.d_rvalid !== 1'b1 || bus.rdata !== 32'hDEAD_BEEF)) begin
                errors++;
                $display("FAIL single_read_data got rv=%b %h want rv=1 deadbeef", bus.d_rvalid, bus.rdata);
            end
            commit(0, won);
        end
    endtask

    task automatic test_contention();
        logic [VW-1:0] obs, expv;
        int won, own, want;
        idle_inputs();
        dr = 1; ir = 1; sr = 1;
        da = 32'h200; ia = 32'h204; sa = 32'h208;
        for (int i = 0; i < 8; i++) begin
            apply(0);
            obs = observe_vec(); expv = expect_vec();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL contention cyc %0d got %h want %h", i, obs, expv);
            end
            own  = bus.d_gnt ? 1 : bus.i_gnt ? 2 : bus.s_gnt ? 3 : 0;
            want = (i == 4) ? 3 : 1;
            checks++;
            if (own !== want || (i == 4 && bus.cpu_stall !== 1'b1)) begin
                errors++;
                $display("FAIL contention_owner cyc %0d got %0d stall %b want %0d", i, own, bus.cpu_stall, want);
            end
            commit(0, won);
        end
    endtask

    task automatic test_write_read();
        logic [VW-1:0] obs, expv;
        int won;
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            if (i == 0) begin sr = 1; swe = 1; sa = 32'h100; swd = 32'h1234_5678; end
            if (i == 1) begin ir = 1; ia = 32'h100; end
            apply(0);
            obs = observe_vec(); expv = expect_vec();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL write_read cyc %0d got %h want %h", i, obs, expv);
            end
            if (i == 1) begin
                checks++;
                if (bus.s_rvalid !== 1'b0 || bus.i_gnt !== 1'b1) begin
                    errors++;
                    $display("FAIL write_no_rvalid got s_rvalid %b i_gnt %b want 0 1", bus.s_rvalid, bus.i_gnt);
                end
            end
            if (i == 2) begin
                checks++;
                if (bus.i_rvalid !== 1'b1 || bus.rdata !== 32'h1234_5678) begin
                    errors++;
                    $display("FAIL write_read_data got rv=%b %h want rv=1 12345678", bus.i_rvalid, bus.rdata);
                end
            end
            commit(0, won);
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] obs, expv;
        int won;
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            if (i < 3) begin ir = 1; ia = W'(i * 4); end
            apply(0);
            obs = observe_vec(); expv = expect_vec();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL back_to_back cyc %0d got %h want %h", i, obs, expv);
            end
            if (i > 0) begin
                checks++;
                if (bus.i_rvalid !== 1'b1 || bus.rdata !== init_word(i - 1)) begin
                    errors++;
                    $display("FAIL back_to_back_data cyc %0d got rv=%b %h want rv=1 %h", i, bus.i_rvalid, bus.rdata, init_word(i - 1));
                end
            end
            commit(0, won);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [VW-1:0] obs, expv;
        int won;
        idle_inputs();
        ir = 1; ia = 32'h10;
        apply(0);
        obs = observe_vec(); expv = expect_vec();
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL mid_read_issue got %h want %h", obs, expv);
        end
        commit(0, won);
        dr = 1; da = 32'h20;
        apply(1);
        obs = observe_vec();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL mid_read_reset got %h want 0", obs);
        end
        commit(1, won);
        // After release, SPI must wait a full streak again.
        idle_inputs();
        dr = 1; sr = 1; da = 32'h24; sa = 32'h28;
        for (int i = 0; i < 6; i++) begin
            apply(0);
            obs = observe_vec(); expv = expect_vec();
            checks++;
            if (obs !== expv || bus.s_gnt !== (i == 4)) begin
                errors++;
                $display("FAIL mid_read_after cyc %0d got %h want %h", i, obs, expv);
            end
            commit(0, won);
        end
    endtask

    task automatic test_abandon();
        logic [VW-1:0] obs, expv;
        int won;
        idle_inputs();
        apply(0);
        commit(0, won);
        for (int i = 0; i < 9; i++) begin
            dr = 1; da = 32'h30; sa = 32'h34;
            sr = (i != 3);
            apply(0);
            obs = observe_vec(); expv = expect_vec();
            checks++;
            if (obs !== expv || bus.s_gnt !== (i == 8)) begin
                errors++;
                $display("FAIL abandon cyc %0d got %h sgnt %b want %h", i, obs, bus.s_gnt, expv);
            end
            commit(0, won);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [VW-1:0] obs, expv;
        int won;
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            if (!dr) begin
                if ($urandom_range(0, 2) == 0) begin
                    dr = 1; dwe = 1'($urandom_range(0, 1));
                    da = {22'b0, 8'($urandom_range(0, 255)), 2'b00}; dwd = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) dr = 0;
            if (!ir) begin
                if ($urandom_range(0, 2) == 0) begin
                    ir = 1; ia = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
                end
            end else if ($urandom_range(0, 15) == 0) ir = 0;
            if (!sr) begin
                if ($urandom_range(0, 2) == 0) begin
                    sr = 1; swe = 1'($urandom_range(0, 1));
                    sa = {22'b0, 8'($urandom_range(0, 255)), 2'b00}; swd = $urandom;
                end
            end else if ($urandom_range(0, 31) == 0) sr = 0;
            apply(0);
            obs = observe_vec(); expv = expect_vec();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL random cyc %0d got %h want %h", c, obs, expv);
            end
            commit(0, won);
            if (won == 1) dr = 0;
            if (won == 2) ir = 0;
            if (won == 3) sr = 0;
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        bus.d_req = 0; bus.i_req = 0; bus.s_req = 0; bus.d_we = 0; bus.s_we = 0;
        bus.d_addr = '0; bus.i_addr = '0; bus.s_addr = '0;
        bus.d_wdata = '0; bus.s_wdata = '0;
        m_age = 0; m_rsel = 0; m_rexp = '0;
        for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);

        test_reset();
        test_single_read();
        test_contention();
        test_write_read();
        test_back_to_back();
        test_reset_mid_read();
        test_abandon();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
